// File: rtl/fp_pkg.sv
// Shared single-precision types, constants and helpers for the adder/subtracter datapath.
package fp_pkg;

    localparam int FRAC_W = 23;
    localparam int EXP_W  = 8;

    localparam logic [EXP_W-1:0] EXP_MAX        = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_MAX_FINITE = 8'hFE;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rm_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Overflowed results saturate to infinity only when rounding away from zero.
    function automatic fp32_t overflow_value(rm_e rm, logic sign);
        fp32_t v;
        logic  to_inf;
        to_inf = (rm == RM_RNE) || (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
        v.sign = sign;
        v.exp  = to_inf ? EXP_MAX : EXP_MAX_FINITE;
        v.frac = to_inf ? '0 : '1;
        return v;
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Mode-aware rounding decision: whether to bump the kept fraction and whether bits were lost.
module fp_round_decide
    import fp_pkg::*;
(
    input  rm_e        rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic [2:0] grs,
    output logic       inc,
    output logic       inexact
);

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        inc     = 1'b0;
        inexact = |grs;
        unique case (rm)
            RM_RNE: inc = grs[2] & (grs[1] | grs[0] | lsb);
            RM_RTZ: inc = 1'b0;
            RM_RUP: inc = ~sign & (|grs);
            RM_RDN: inc = sign & (|grs);
        endcase
    end

endmodule

// File: rtl/fp_round_pack.sv
// Final round-and-pack stage: two-stage valid/ready pipeline producing packed IEEE-754 singles.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter logic [1:0] RM = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [FRAC_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [2:0]        GRS_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              inexact,
    output logic              overflow,
    input  logic              flags_clr,
    output logic              flag_inexact_sticky,
    output logic              flag_overflow_sticky
);

    localparam rm_e RM_MODE = rm_e'(RM);

    logic round_inc;
    logic round_inexact;

    fp_round_decide u_decide (
        .rm      (RM_MODE),
        .sign    (sign_in),
        .lsb     (mant_in[0]),
        .grs     (GRS_in),
        .inc     (round_inc),
        .inexact (round_inexact)
    );

    logic              v1;
    logic              v2;
    logic              s1_ready;
    logic              s2_ready;
    logic              s1_sign;
    logic              s1_inexact;
    logic              s1_sat;
    logic              s1_zero;
    logic [EXP_W-1:0]  s1_exp;
    logic [FRAC_W:0]   s1_sum;

    assign s2_ready  = ~v2 | out_ready;
    assign s1_ready  = ~v1 | s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            v1 <= 1'b0;
        end else if (s1_ready) begin
            v1 <= in_valid;
        end
    end

    // NOTE: stage-1 payload carries no reset; v1 alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (in_valid && s1_ready) begin
            s1_sign    <= sign_in;
            s1_exp     <= exp_in;
            s1_zero    <= (exp_in == '0);
            s1_sat     <= (exp_in == EXP_MAX);
            s1_inexact <= (exp_in == '0) ? (|{mant_in, GRS_in}) : round_inexact;
            s1_sum     <= {1'b0, mant_in} + {{FRAC_W{1'b0}}, round_inc};
        end
    end

    // Nine-bit exponent so a round carry out of 8'hFE is seen as overflow.
    logic [EXP_W:0] s2_exp_sum;
    fp32_t          s2_next;
    logic           s2_next_inexact;
    logic           s2_next_overflow;

    always_comb begin
        s2_exp_sum       = {1'b0, s1_exp} + {{EXP_W{1'b0}}, s1_sum[FRAC_W]};
        s2_next.sign     = s1_sign;
        s2_next.exp      = s2_exp_sum[EXP_W-1:0];
        s2_next.frac     = s1_sum[FRAC_W] ? '0 : s1_sum[FRAC_W-1:0];
        s2_next_inexact  = s1_inexact;
        s2_next_overflow = 1'b0;
        if (s1_zero) begin
            s2_next = {s1_sign, 31'b0};
        end else if (s1_sat || s2_exp_sum >= {1'b0, EXP_MAX}) begin
            s2_next          = overflow_value(RM_MODE, s1_sign);
            s2_next_inexact  = 1'b1;
            s2_next_overflow = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2                   <= 1'b0;
            result               <= '0;
            inexact              <= 1'b0;
            overflow             <= 1'b0;
            flag_inexact_sticky  <= 1'b0;
            flag_overflow_sticky <= 1'b0;
        end else begin
            if (s2_ready) begin
                v2 <= v1;
                if (v1) begin
                    result   <= s2_next;
                    inexact  <= s2_next_inexact;
                    overflow <= s2_next_overflow;
                end
            end
            // A clear coinciding with a new event still leaves the event recorded.
            if (v2 && out_ready) begin
                flag_inexact_sticky  <= (flags_clr ? 1'b0 : flag_inexact_sticky) | inexact;
                flag_overflow_sticky <= (flags_clr ? 1'b0 : flag_overflow_sticky) | overflow;
            end else if (flags_clr) begin
                flag_inexact_sticky  <= 1'b0;
                flag_overflow_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench: one DUT per rounding mode, shared stimulus, arithmetic reference model.
module tb_fp_round_pack;

    typedef struct packed {
        logic [31:0] res;
        logic        inx;
        logic        ovf;
    } out_t;
    typedef out_t [3:0] row_t;

    typedef struct {
        logic        s;
        logic [22:0] f;
        logic [7:0]  e;
        logic [2:0]  grs;
        int          m;
        logic [31:0] res;
        logic        inx;
        logic        ovf;
    } dcase_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        sign_in   = 1'b0;
    logic        out_ready = 1'b0;
    logic        flags_clr = 1'b0;
    logic [22:0] mant_in   = '0;
    logic [7:0]  exp_in    = '0;
    logic [2:0]  grs_in    = '0;

    logic [3:0]       in_ready;
    logic [3:0]       out_valid;
    logic [3:0]       inexact;
    logic [3:0]       overflow;
    logic [3:0]       flag_inexact_sticky;
    logic [3:0]       flag_overflow_sticky;
    logic [3:0][31:0] result;

    int     tests    = 0;
    int     failures = 0;
    bit     accepted = 1'b0;
    row_t   exp_q[$];
    row_t   obs_q[$];
    dcase_t dcases[12];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fp_round_pack #(.RM(2'(g))) u_dut (
            .clk                  (clk),
            .rst                  (rst),
            .in_valid             (in_valid),
            .in_ready             (in_ready[g]),
            .sign_in              (sign_in),
            .mant_in              (mant_in),
            .exp_in               (exp_in),
            .GRS_in               (grs_in),
            .out_valid            (out_valid[g]),
            .out_ready            (out_ready),
            .result               (result[g]),
            .inexact              (inexact[g]),
            .overflow             (overflow[g]),
            .flags_clr            (flags_clr),
            .flag_inexact_sticky  (flag_inexact_sticky[g]),
            .flag_overflow_sticky (flag_overflow_sticky[g])
        );
    end

    // Reference: round the 24-bit significand by comparing the discarded bits to one half.
    function automatic out_t model(int m, logic s, logic [22:0] f, logic [7:0] e, logic [2:0] grs);
        out_t o;
        int   sig;
        int   ex;
        bit   up;
        bit   to_inf;
        o.inx = (grs != 0);
        o.ovf = 1'b0;
        if (e == 0) begin
            o.res = {s, 31'b0};
            o.inx = (f != 0) || (grs != 0);
            return o;
        end
        case (m)
            0:       up = (grs > 3'b100) || (grs == 3'b100 && f[0]);
            1:       up = 1'b0;
            2:       up = !s && (grs != 0);
            default: up = s && (grs != 0);
        endcase
        sig = (1 << 23) + int'(f) + int'(up);
        ex  = int'(e);
        if (sig == (1 << 24)) begin
            sig = 1 << 23;
            ex  = ex + 1;
        end
        if (e == 8'hFF || ex >= 255) begin
            to_inf = (m == 0) || (m == 2 && !s) || (m == 3 && s);
            o.ovf  = 1'b1;
            o.inx  = 1'b1;
            o.res  = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
        end else begin
            o.res = {s, 8'(ex), 23'(sig - (1 << 23))};
        end
        return o;
    endfunction

    // Advances one clock; records accepted inputs (as model predictions) and delivered outputs.
    task automatic cycle();
        row_t r;
        @(negedge clk);
        accepted = in_valid && in_ready[0];
        if (!rst) begin
            if (accepted) begin
                r = '0;
                for (int g = 0; g < 4; g++) r[g] = model(g, sign_in, mant_in, exp_in, grs_in);
                exp_q.push_back(r);
            end
            if (out_valid[0] && out_ready) begin
                r = '0;
                for (int g = 0; g < 4; g++) r[g] = '{res: result[g], inx: inexact[g], ovf: overflow[g]};
                obs_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_input();
        int k;
        k       = $urandom_range(0, 9);
        sign_in = 1'($urandom);
        mant_in = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
        grs_in  = 3'($urandom);
        case (k)
            0:       exp_in = 8'h00;
            1, 2:    exp_in = 8'hFE;
            3:       exp_in = 8'hFF;
            4:       exp_in = 8'h7F;
            default: exp_in = 8'($urandom);
        endcase
    endtask

    task automatic send_one(input logic s, input logic [22:0] f, input logic [7:0] e, input logic [2:0] grs);
        sign_in  = s;
        mant_in  = f;
        exp_in   = e;
        grs_in   = grs;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (accepted) break;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && obs_q.size() == 0; i++) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        tests++;
        if (out_valid !== 4'h0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0000", out_valid);
        end
        tests++;
        if (in_ready !== 4'hF) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1111", in_ready);
        end
        tests++;
        if (result !== '0 || inexact !== 4'h0 || overflow !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs: got result=%h inexact=%b overflow=%b expected all zero",
                     result, inexact, overflow);
        end
        tests++;
        if (flag_inexact_sticky !== 4'h0 || flag_overflow_sticky !== 4'h0) begin
            failures++;
            $display("FAIL reset_sticky: got %b/%b expected 0000/0000", flag_inexact_sticky, flag_overflow_sticky);
        end
    endtask

    task automatic test_directed();
        row_t o;
        dcases[0]  = '{1'b0, 23'h000001, 8'h7F, 3'b100, 0, 32'h3F800002, 1'b1, 1'b0};
        dcases[1]  = '{1'b0, 23'h000000, 8'h7F, 3'b100, 0, 32'h3F800000, 1'b1, 1'b0};
        dcases[2]  = '{1'b0, 23'h7FFFFF, 8'h80, 3'b110, 0, 32'h40800000, 1'b1, 1'b0};
        dcases[3]  = '{1'b0, 23'h7FFFFF, 8'hFE, 3'b100, 0, 32'h7F800000, 1'b1, 1'b1};
        dcases[4]  = '{1'b0, 23'h7FFFFF, 8'hFE, 3'b100, 1, 32'h7F7FFFFF, 1'b1, 1'b0};
        dcases[5]  = '{1'b0, 23'h7FFFFF, 8'hFE, 3'b100, 3, 32'h7F7FFFFF, 1'b1, 1'b0};
        dcases[6]  = '{1'b0, 23'h000000, 8'hFF, 3'b000, 0, 32'h7F800000, 1'b1, 1'b1};
        dcases[7]  = '{1'b1, 23'h000000, 8'hFF, 3'b000, 2, 32'hFF7FFFFF, 1'b1, 1'b1};
        dcases[8]  = '{1'b1, 23'h000005, 8'h00, 3'b000, 0, 32'h80000000, 1'b1, 1'b0};
        dcases[9]  = '{1'b0, 23'h123456, 8'h7F, 3'b000, 0, 32'h3F923456, 1'b0, 1'b0};
        dcases[10] = '{1'b1, 23'h7FFFFF, 8'hFE, 3'b001, 3, 32'hFF800000, 1'b1, 1'b1};
        dcases[11] = '{1'b0, 23'h7FFFFF, 8'hFE, 3'b001, 2, 32'h7F800000, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_q.delete();
            obs_q.delete();
            send_one(dcases[i].s, dcases[i].f, dcases[i].e, dcases[i].grs);
            tests++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL directed_%0d_timeout: got no output expected one result", i);
            end else begin
                o = obs_q.pop_front();
                if (o[dcases[i].m] !== '{res: dcases[i].res, inx: dcases[i].inx, ovf: dcases[i].ovf}) begin
                    failures++;
                    $display("FAIL directed_%0d mode%0d: got %h inx=%b ovf=%b expected %h inx=%b ovf=%b",
                             i, dcases[i].m, o[dcases[i].m].res, o[dcases[i].m].inx, o[dcases[i].m].ovf,
                             dcases[i].res, dcases[i].inx, dcases[i].ovf);
                end
            end
        end
    endtask

    task automatic test_sticky();
        exp_q.delete();
        obs_q.delete();
        out_ready = 1'b0;
        flags_clr = 1'b0;
        sign_in   = 1'b0;
        mant_in   = 23'h000010;
        exp_in    = 8'h7F;
        grs_in    = 3'b011;
        in_valid  = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid[0]; i++) cycle();
        tests++;
        if (out_valid !== 4'hF) begin
            failures++;
            $display("FAIL sticky_wait_valid: got %b expected 1111", out_valid);
        end
        out_ready = 1'b1;
        flags_clr = 1'b1;
        cycle();
        tests++;
        if (flag_inexact_sticky !== 4'hF) begin
            failures++;
            $display("FAIL sticky_clr_with_event: got %b expected 1111", flag_inexact_sticky);
        end
        tests++;
        if (flag_overflow_sticky !== 4'h0) begin
            failures++;
            $display("FAIL sticky_clr_overflow: got %b expected 0000", flag_overflow_sticky);
        end
        cycle();
        flags_clr = 1'b0;
        tests++;
        if (flag_inexact_sticky !== 4'h0) begin
            failures++;
            $display("FAIL sticky_clr_idle: got %b expected 0000", flag_inexact_sticky);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        int          sent;
        row_t        o;
        row_t        e;
        exp_q.delete();
        obs_q.delete();
        sent      = 0;
        held      = '0;
        out_ready = 1'b0;
        randomize_input();
        for (int c = 0; c < 5; c++) begin
            in_valid = (sent < 4);
            cycle();
            if (accepted) begin
                sent++;
                randomize_input();
            end
            if (c == 1) held = result[0];
        end
        tests++;
        if (sent != 2 || in_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall_accepts: got %0d accepts in_ready=%b expected 2 accepts in_ready=0",
                     sent, in_ready[0]);
        end
        tests++;
        if (out_valid[0] !== 1'b1 || result[0] !== held) begin
            failures++;
            $display("FAIL b2b_stall_hold: got valid=%b result=%h expected valid=1 result=%h",
                     out_valid[0], result[0], held);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (sent < 4);
            cycle();
            if (accepted) begin
                sent++;
                randomize_input();
            end
        end
        in_valid = 1'b0;
        tests++;
        if (obs_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_drain_rate: got %0d results in 4 cycles expected 4", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            for (int g = 0; g < 4; g++) begin
                tests++;
                if (o[g] !== e[g]) begin
                    failures++;
                    $display("FAIL b2b_order mode%0d: got %h/%b/%b expected %h/%b/%b",
                             g, o[g].res, o[g].inx, o[g].ovf, e[g].res, e[g].inx, e[g].ovf);
                end
            end
        end
    endtask

    task automatic test_random();
        row_t o;
        row_t e;
        exp_q.delete();
        obs_q.delete();
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || accepted) begin
                randomize_input();
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            for (int g = 0; g < 4; g++) begin
                tests++;
                if (o[g] !== e[g]) begin
                    failures++;
                    $display("FAIL random mode%0d: got %h/%b/%b expected %h/%b/%b",
                             g, o[g].res, o[g].inx, o[g].ovf, e[g].res, e[g].inx, e[g].ovf);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        obs_q.delete();
        out_ready = 1'b1;
        send_one(1'b0, 23'h000123, 8'h7F, 3'b001);
        out_ready = 1'b0;
        randomize_input();
        in_valid = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        tests++;
        if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || flag_inexact_sticky !== 4'hF) begin
            failures++;
            $display("FAIL midrst_setup: got valid=%b ready=%b sticky=%b expected 1/0/1111",
                     out_valid[0], in_ready[0], flag_inexact_sticky);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests++;
        if (out_valid !== 4'h0 || in_ready !== 4'hF) begin
            failures++;
            $display("FAIL midrst_handshake: got valid=%b ready=%b expected 0000/1111", out_valid, in_ready);
        end
        tests++;
        if (flag_inexact_sticky !== 4'h0 || flag_overflow_sticky !== 4'h0 || result !== '0) begin
            failures++;
            $display("FAIL midrst_state: got sticky=%b/%b result=%h expected zeros",
                     flag_inexact_sticky, flag_overflow_sticky, result);
        end
        exp_q.delete();
        obs_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        tests++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_no_output: got %0d results expected 0", obs_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_sticky();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/fp_round_pack.md
# fp_round_pack

Final rounding-and-packing stage of the single-precision adder/subtracter datapath, directly downstream of post-normalization. Takes the normalized sign, 23-bit fraction, biased exponent and guard/round/sticky bits. Applies the configured IEEE-754 rounding mode, handles round-carry renormalization and exponent overflow, and emits a packed 32-bit result. Implemented as a 2-stage valid/ready pipeline with sticky exception flags.

## Interface
- `RM`, default `2'b00`: rounding mode. `00` RNE, `01` RTZ, `10` RUP (toward +inf), `11` RDN (toward -inf).
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream operand valid
- `in_ready`  out  1  block can accept this cycle
- `sign_in`  in  1  result sign
- `mant_in`  in  23  normalized fraction; leading 1 is implicit
- `exp_in`  in  8  biased exponent; `8'hFF` means already saturated upstream
- `GRS_in`  in  3  guard, round, sticky (bit 2 = G)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `result`  out  32  packed `{sign, exp[7:0], frac[22:0]}`
- `inexact`  out  1  per-result flag, qualified by `out_valid`
- `overflow`  out  1  per-result flag, qualified by `out_valid`
- `flags_clr`  in  1  clears the sticky flags
- `flag_inexact_sticky`  out  1  accumulated inexact
- `flag_overflow_sticky`  out  1  accumulated overflow

## Operation
- **Transfer:** a transfer happens when valid and ready are both high on a port. There is no combinational path from `in_valid` to `out_valid`.
- **Increment decision, `inc`:**
  - RNE: `G & (R | S | mant_in[0])`
  - RTZ: `0`
  - RUP: `~sign & (G | R | S)`
  - RDN: `sign & (G | R | S)`
- **Inexact:** `inexact = |GRS_in`.
- **Stage 1 registers:** sign, exp, inexact, and a 24-bit `sum = {1'b0, mant_in} + inc`.
- **Stage 2, carry:** if `sum[23]`, then frac = 0 and exp = exp + 1. Otherwise frac = `sum[22:0]`. Exponent arithmetic is 9-bit so that the carry from `8'hFE` is detected.
- **Stage 2, overflow:** overflow is set when the final exp ≥ `8'hFF`, or when `exp_in` was `8'hFF`. Overflow forces `inexact = 1`. The overflow result depends on `RM` and sign:
  - RNE: ±inf (`exp FF`, `frac 0`)
  - RTZ: ±max finite (`exp FE`, `frac 7FFFFF`)
  - RUP: +inf if sign = 0, else -max finite
  - RDN: -inf if sign = 1, else +max finite
- **Zero / underflow:** if `exp_in == 0`, output signed zero (`{sign, 31'b0}`), no rounding. `inexact = |{mant_in, GRS_in}`. Denormals are flushed to zero.
- **Sticky flags:** on each output transfer, `flag_x <= (flags_clr ? 0 : flag_x) | x`. A new event in the same cycle as `flags_clr` leaves the flag set. With no transfer, `flags_clr` simply clears.

## Timing
- **Latency:** exactly 2 cycles from input transfer to `out_valid` when unstalled. Throughput is 1 result per cycle.
- **Ready logic:**
  - `s2_ready = ~v2 | out_ready`
  - `s1_ready = ~v1 | s2_ready`
  - `in_ready = s1_ready` (combinational from `out_ready` and state only)
- **Stall:** while `out_valid & ~out_ready`, `result`, `inexact` and `overflow` hold stable.
  - Up to 2 operands are buffered; `in_ready` falls when both stages are full.
  - No data is dropped or duplicated, and order is preserved.
- **Reset:**
  - `v1 = v2 = 0`, so `out_valid = 0` and `in_ready = 1` in the cycle after reset.
  - `result = 0`, `inexact = overflow = 0`, both sticky flags = 0.
  - Reset mid-operation discards in-flight data with no partial output.
- **Simultaneous events:** a stage may load and unload in the same cycle when full and the downstream is ready.

## Structure
- **Shared package `fp_pkg`:**
  - `rm_e` enum (`RM_RNE`, `RM_RTZ`, `RM_RUP`, `RM_RDN`)
  - `EXP_MAX = 8'hFF`
  - `EXP_MAX_FINITE = 8'hFE`
  - `FRAC_W = 23`, `EXP_W = 8`
  - packed struct `fp32_t {sign, exp, frac}`
- **Sub-module `fp_round_decide`:** combinational; takes `rm`, `sign`, `lsb`, `GRS` and outputs `inc`, `inexact`. It is reused by any future mode-aware stage.
- **Top-level registers:** pipeline registers and flags live in `fp_round_pack`.

## Test plan
1. **RNE tie to even:** RNE, `exp 7F`.
   - `mant 000001`, `GRS 100` → `3F800002`, `inexact = 1`.
   - `mant 000000`, `GRS 100` → `3F800000`, `inexact = 1`.
2. **Round carry:** RNE, `sign 0`, `exp 80`, `mant 7FFFFF`, `GRS 110` → `40800000`, `inexact = 1`, `overflow = 0`.
3. **Overflow by mode:** `exp FE`, `mant 7FFFFF`, `GRS 100`.
   - RNE → `7F800000`, `overflow = 1`.
   - RTZ → `7F7FFFFF`.
   - RDN with `sign 0` → `7F7FFFFF`.
   - `exp_in FF` under RNE → `7F800000`.
4. **Backpressure:** 4 back-to-back inputs with `out_ready` low for 5 cycles.
   - `in_ready` drops after 2 accepts; `result` is stable while stalled.
   - All 4 results are delivered in order, 1 per cycle once `out_ready` rises.
5. **Reset mid-operation:** `rst` high for 1 cycle with both stages full → next cycle `out_valid = 0`, `in_ready = 1`, sticky flags = 0.
6. **Sticky flags:** an inexact result transfers in the same cycle as `flags_clr` → `flag_inexact_sticky` remains 1. `flags_clr` alone on the next idle cycle → flag becomes 0.
